// File: rtl/shake_arbiter_pkg.sv
// Shared types and widths for the SHAKE core arbiter.
// Imported by the arbiter top and its round-robin picker.
package shake_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int TMO_DEF  = 255;
  localparam int DIG_W    = 512;
  localparam int BLK_W    = 1024;
  localparam int LEN_W    = 7;
  localparam int WDG_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shake_arbiter_rr_arb.sv
// Combinational round-robin picker for the SHAKE arbiter.
// Searches upward from the slot after the last owner.
module rr_arb
  import shake_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [IW-1:0]   o_win,
  output logic            o_found
);

  logic [NREQ-1:0] w_rot;

  // rotate so bit 0 is the slot after last owner; lowest set bit wins
  always_comb begin
    w_rot   = NREQ'({i_req, i_req} >> (32'(i_last) + 32'd1));
    o_win   = '0;
    o_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        o_win   = IW'((32'(i_last) + 32'd1 + 32'(k)) % 32'(NREQ));
      end
    end
  end

endmodule

// File: rtl/shake_arbiter.sv
// Shares one SHAKE sponge core between NREQ requesters.
// One job at a time: pick, issue, wait (with watchdog), respond.
module shake_arbiter
  import shake_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TMO_CYC = TMO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BLK_W-1:0] req_din,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ-1:0]       req_mode,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [DIG_W-1:0]      rsp_dout,
  output logic                  rsp_err,
  output logic [BLK_W-1:0]      core_din,
  output logic [LEN_W-1:0]      core_byte_len,
  output logic                  core_mode,
  output logic                  core_valid,
  output logic                  core_last,
  input  logic                  core_ack,
  input  logic                  core_done,
  input  logic                  core_busy,
  input  logic [DIG_W-1:0]      core_dout
);

  localparam int IW = idx_w(NREQ);
  localparam logic [WDG_W-1:0] TMO_LIM = WDG_W'(TMO_CYC);
  localparam logic [NREQ-1:0]  ONE     = NREQ'(1);

  arb_state_t       r_state;
  arb_state_t       w_nxt;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    w_win;
  logic             w_found;
  logic [WDG_W-1:0] r_wdog;
  logic [WDG_W-1:0] w_wdog_nxt;
  logic [NREQ-1:0]  r_gnt;
  logic [BLK_W-1:0] r_din;
  logic [LEN_W-1:0] r_len;
  logic             r_mode;
  logic [DIG_W-1:0] r_dout;
  logic             r_err;
  logic [BLK_W-1:0] w_sel_din;
  logic [LEN_W-1:0] w_sel_len;
  logic             w_sel_mode;
  logic             w_latch;
  logic             w_acc;
  logic             w_ok;
  logic             w_tmo;

  rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_req   (req),
    .i_last  (r_last),
    .o_win   (w_win),
    .o_found (w_found)
  );

  assign w_wdog_nxt = r_wdog + 1'b1;

  // message fields of the round-robin winner
  always_comb begin
    w_sel_din  = '0;
    w_sel_len  = '0;
    w_sel_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) begin
        w_sel_din  = req_din[i*BLK_W +: BLK_W];
        w_sel_len  = req_len[i*LEN_W +: LEN_W];
        w_sel_mode = req_mode[i];
      end
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_nxt;
  end

  // next state and job events; done beats a same-cycle timeout
  always_comb begin
    w_nxt   = r_state;
    w_latch = 1'b0;
    w_acc   = 1'b0;
    w_ok    = 1'b0;
    w_tmo   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found && !core_busy) begin
          w_latch = 1'b1;
          w_nxt   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (core_ack) begin
          w_acc = 1'b1;
          w_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (core_done && !core_busy) begin
          w_ok  = 1'b1;
          w_nxt = ST_RESP;
        end else if (w_wdog_nxt == TMO_LIM) begin
          w_tmo = 1'b1;
          w_nxt = ST_RESP;
        end
      end
      ST_RESP: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // owner and core fields, frozen from issue until the response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= '0;
      r_din   <= '0;
      r_len   <= '0;
      r_mode  <= 1'b0;
    end else if (w_latch) begin
      r_owner <= w_win;
      r_din   <= w_sel_din;
      r_len   <= w_sel_len;
      r_mode  <= w_sel_mode;
    end
  end

  // grant pulse and watchdog
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt  <= '0;
      r_wdog <= '0;
    end else begin
      r_gnt <= '0;
      if (w_acc) begin
        r_gnt  <= ONE << r_owner;
        r_wdog <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wdog <= w_wdog_nxt;
      end
    end
  end

  // digest capture and round-robin pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
      r_err  <= 1'b0;
      r_last <= IW'(NREQ - 1);
    end else begin
      if (w_ok) begin
        r_dout <= core_dout;
        r_err  <= 1'b0;
      end else if (w_tmo) begin
        r_dout <= '0;
        r_err  <= 1'b1;
      end
      if (r_state == ST_RESP) r_last <= r_owner;
    end
  end

  assign gnt           = r_gnt;
  assign rsp_valid     = (r_state == ST_RESP) ? (ONE << r_owner) : '0;
  assign rsp_dout      = r_dout;
  assign rsp_err       = r_err;
  assign core_din      = r_din;
  assign core_byte_len = r_len;
  assign core_mode     = r_mode;
  assign core_valid    = (r_state == ST_ISSUE);
  assign core_last     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);

endmodule

// File: doc/shake_arbiter.md
SHAKE_ARBITER -- requirements
Module: shake_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one SHAKE sponge core.
REQ-002 Parameter TMO_CYC, default 255, watchdog limit in cycles from core accept to core done.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester request level; held high until its rsp_valid bit pulses.
REQ-006 req_din  input  NREQ*1024  per-requester single-block message, slot i at bits [i*1024 +: 1024].
REQ-007 req_len  input  NREQ*7  per-requester message byte length, slot i at bits [i*7 +: 7].
REQ-008 req_mode  input  NREQ  per-requester mode: 0 SHAKE128, 1 SHAKE256.
REQ-009 gnt  output  NREQ  one-hot, one-cycle pulse when the core accepts that requester's message.
REQ-010 rsp_valid  output  NREQ  one-hot, one-cycle pulse marking rsp_dout/rsp_err valid for that requester.
REQ-011 rsp_dout  output  512  shared digest bus, valid only while a rsp_valid bit is high.
REQ-012 rsp_err  output  1  high with rsp_valid when the job ended by watchdog timeout.
REQ-013 core_din  output  1024, core_byte_len output 7, core_mode output 1: message fields to the sponge core.
REQ-014 core_valid  output  1, core_last  output 1: request strobe and last-block flag to the core.
REQ-015 core_ack  input  1, core_done  input 1, core_busy  input 1, core_dout  input 512: core status and digest.

Function
REQ-016 States IDLE, ISSUE, WAIT, RESP; encoding from the shared package.
REQ-017 IDLE: if any req bit is high and core_busy is low, latch the round-robin winner as owner and go to ISSUE; else stay.
REQ-018 Round-robin: search starts at (last_owner+1) mod NREQ; last_owner resets to NREQ-1, so requester 0 wins first after reset.
REQ-019 ISSUE: core_valid=1, core_last=1, core fields mux from owner slot; on core_ack=1 pulse gnt[owner] next cycle, clear watchdog, go to WAIT.
REQ-020 core_last SHALL stay 1 from ISSUE through WAIT (only single-block messages are issued).
REQ-021 core_din, core_byte_len and core_mode SHALL be registered at entry to ISSUE and held constant until RESP exits.
REQ-022 WAIT: increment 8-bit watchdog each cycle; on core_done=1 and core_busy=0 capture core_dout into rsp_dout, rsp_err=0, go to RESP.
REQ-023 WAIT: watchdog reaching TMO_CYC without done captures rsp_dout=0, rsp_err=1, go to RESP.
REQ-024 If done and timeout occur in the same cycle, done wins (rsp_err=0).
REQ-025 RESP: rsp_valid[owner]=1 for exactly one cycle, last_owner<=owner, return to IDLE.
REQ-026 Requester drop: a req bit falling after grant SHALL NOT abort the job; the response is still pulsed.
REQ-027 Fairness: a continuously requesting requester is served within NREQ jobs.
REQ-028 Latency: req to gnt is 3 cycles minimum with an idle core (IDLE, ISSUE, core ack registered); done to rsp_valid is 1 cycle.
REQ-029 Never more than one job outstanding; a new req is not considered until RESP completes.

Reset
REQ-030 On rst low: state IDLE, gnt=0, rsp_valid=0, rsp_dout=0, rsp_err=0, core_valid=0, core_last=0, core fields 0, watchdog 0, last_owner NREQ-1.
REQ-031 Reset mid-job aborts silently: no rsp_valid pulse; the core is reset by the same rst.

Structure
REQ-032 Shared package holds state encoding, NREQ default, TMO_CYC default, digest width 512, block width 1024.
REQ-033 One sub-module rr_arb: combinational round-robin picker (req vector, last_owner in; winner index and found flag out).
REQ-034 Sponge core is instantiated outside this block and connected via the core_* ports.

Verification
REQ-035 Single req[0], len=0, mode=0 -> gnt[0] pulse, rsp_valid[0] pulse, rsp_dout equals SHAKE128("") first 512 bits (7f9c2ba4...).
REQ-036 req=4'b1111 held, all mode=1 -> grants in order 0,1,2,3,0, each rsp_valid matches its gnt owner, no overlap.
REQ-037 req[2] asserted while job for 1 in WAIT -> not granted until rsp_valid[1] pulses, then gnt[2].
REQ-038 Core model never asserts done -> rsp_valid[owner] with rsp_err=1, rsp_dout=0, exactly TMO_CYC cycles after gnt.
REQ-039 rst low during WAIT -> all outputs zero next cycle, no rsp_valid; after release, req[0] granted first.
REQ-040 req[3] dropped one cycle after gnt[3] -> rsp_valid[3] still pulses with correct SHAKE256 digest.
